// File: rtl/sub1_bit_deposit_pkg.sv
// Shared lookup definitions: FSM encoding, default widths and the MSB-first
// bit-index mapping used by both the single-bit extractor and this deposit block.
package sub1_bit_deposit_pkg;

  localparam int DEF_SUB_PKTS_LEN  = 8;
  localparam int DEF_L_BIT_ACT_LEN = 3;
  localparam int DEF_CNT_LEN       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // Action index 0 addresses the byte MSB, index 7 the LSB.
  function automatic logic [DEF_L_BIT_ACT_LEN-1:0] bit_pos(
    input logic [DEF_L_BIT_ACT_LEN-1:0] idx
  );
    return DEF_L_BIT_ACT_LEN'(DEF_SUB_PKTS_LEN - 1) - idx;
  endfunction

endpackage

// File: rtl/sub1_bit_deposit_core.sv
// Combinational single-bit write: computes next working byte, next written
// vector and whether the write conflicts with an earlier write to the same bit.
module sub1_bit_deposit_core
  import sub1_bit_deposit_pkg::*;
(
  input  logic [DEF_SUB_PKTS_LEN-1:0]  i_work,
  input  logic [DEF_SUB_PKTS_LEN-1:0]  i_written,
  input  logic [DEF_L_BIT_ACT_LEN-1:0] i_idx,
  input  logic                         i_val,
  input  logic                         i_mask,
  output logic [DEF_SUB_PKTS_LEN-1:0]  o_work,
  output logic [DEF_SUB_PKTS_LEN-1:0]  o_written,
  output logic                         o_hit
);

  logic [DEF_L_BIT_ACT_LEN-1:0] pos;

  always_comb begin
    pos       = bit_pos(i_idx);
    o_work    = i_work;
    o_written = i_written;
    o_hit     = 1'b0;
    if (i_mask) begin
      // Conflict compares against the value before this write; last write wins.
      o_hit          = i_written[pos] && (i_work[pos] != i_val);
      o_work[pos]    = i_val;
      o_written[pos] = 1'b1;
    end
  end

endmodule

// File: rtl/sub1_bit_deposit.sv
// Header byte bit-deposit block: loads a byte, applies masked MSB-first
// single-bit writes, then presents the modified byte with write count and conflict flag.
module sub1_bit_deposit
  import sub1_bit_deposit_pkg::*;
#(
  parameter int SUB_PKTS_LEN  = DEF_SUB_PKTS_LEN,
  parameter int L_BIT_ACT_LEN = DEF_L_BIT_ACT_LEN,
  parameter int CNT_LEN       = DEF_CNT_LEN
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     i_hdr_valid,
  input  logic [SUB_PKTS_LEN-1:0]  i_hdr,
  output logic                     o_hdr_ready,
  input  logic                     i_bit_act_valid,
  input  logic [L_BIT_ACT_LEN-1:0] i_bit_act,
  input  logic                     i_bit_in,
  input  logic                     i_bit_mask,
  input  logic                     i_bit_last,
  output logic                     o_bit_ready,
  output logic                     o_hdr_out_valid,
  output logic [SUB_PKTS_LEN-1:0]  o_hdr_out,
  output logic [CNT_LEN-1:0]       o_wr_cnt,
  output logic                     o_conflict,
  input  logic                     i_hdr_out_ready
);

  localparam logic [CNT_LEN-1:0] CNT_MAX = {CNT_LEN{1'b1}};

  state_e                  state_q, state_d;
  logic [SUB_PKTS_LEN-1:0] work_q, work_d;
  logic [SUB_PKTS_LEN-1:0] written_q, written_d;
  logic [CNT_LEN-1:0]      cnt_q, cnt_d;
  logic                    conflict_q, conflict_d;

  logic [SUB_PKTS_LEN-1:0] core_work;
  logic [SUB_PKTS_LEN-1:0] core_written;
  logic                    core_hit;

  sub1_bit_deposit_core u_core (
    .i_work    (work_q),
    .i_written (written_q),
    .i_idx     (i_bit_act),
    .i_val     (i_bit_in),
    .i_mask    (i_bit_mask),
    .o_work    (core_work),
    .o_written (core_written),
    .o_hit     (core_hit)
  );

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    written_d  = written_q;
    cnt_d      = cnt_q;
    conflict_d = conflict_q;
    case (state_q)
      ST_IDLE: begin
        if (i_hdr_valid) begin
          work_d     = i_hdr;
          written_d  = '0;
          cnt_d      = '0;
          conflict_d = 1'b0;
          state_d    = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (i_bit_act_valid) begin
          work_d    = core_work;
          written_d = core_written;
          if (i_bit_mask && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_LEN'(1);
          end
          if (core_hit) begin
            conflict_d = 1'b1;
          end
          if (i_bit_last) begin
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (i_hdr_out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      written_q  <= '0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      written_q  <= written_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
    end
  end

  // Handshake signals decode from state only, so no input-to-ready paths exist.
  assign o_hdr_ready     = (state_q == ST_IDLE);
  assign o_bit_ready     = (state_q == ST_ACCUM);
  assign o_hdr_out_valid = (state_q == ST_OUT);
  assign o_hdr_out       = work_q;
  assign o_wr_cnt        = cnt_q;
  assign o_conflict      = conflict_q;

endmodule

// File: doc/sub1_bit_deposit.md
# sub1_bit_deposit

Write-side counterpart of the single-bit extractor in the lookup data path. It takes one 8-bit header byte, applies a stream of masked single-bit writes using the same MSB-first 3-bit bit index, and returns the modified byte. Action index 0 addresses bit 7 and index 7 addresses bit 0. The block sits between the action engine and header re-assembly, so that bit-field set actions land at exactly the positions the extractor reads.

## Interface
- SUB_PKTS_LEN, 8, header byte width; only 8 is supported.
- L_BIT_ACT_LEN, 3, bit index width, equal to log2(SUB_PKTS_LEN).
- CNT_LEN, 4, width of the applied-write counter.

- clk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- i_hdr_valid  in  1  header byte offered.
- i_hdr  in  SUB_PKTS_LEN  original header byte.
- o_hdr_ready  out  1  block can accept a header (state IDLE).
- i_bit_act_valid  in  1  bit-write command offered.
- i_bit_act  in  L_BIT_ACT_LEN  bit index, MSB-first.
- i_bit_in  in  1  value to write.
- i_bit_mask  in  1  1 = perform the write; 0 = no-op (still counts toward i_bit_last).
- i_bit_last  in  1  final command for this header.
- o_bit_ready  out  1  block accepts commands (state ACCUM).
- o_hdr_out_valid  out  1  modified byte available.
- o_hdr_out  out  SUB_PKTS_LEN  modified byte.
- o_wr_cnt  out  CNT_LEN  number of masked writes applied; saturates at 2^CNT_LEN-1.
- o_conflict  out  1  a bit was written twice with different values.
- i_hdr_out_ready  in  1  downstream accepts the output.

## Operation
- FSM has three states: IDLE, ACCUM, OUT.
- IDLE:
  - o_hdr_ready=1.
  - On i_hdr_valid: load the working byte from i_hdr, clear the written-bit vector (8b), clear the counter and the conflict flag, go to ACCUM.
- ACCUM:
  - o_bit_ready=1.
  - On i_bit_act_valid with i_bit_mask=1:
    - working[7-i_bit_act] <= i_bit_in.
    - Set written[7-i_bit_act].
    - Increment the counter, saturating.
    - If the written bit was already set and the working value differs from i_bit_in, set conflict (sticky). The last write wins.
  - On i_bit_act_valid with i_bit_mask=0: byte, counter and written vector are unchanged.
  - If i_bit_last is set on an accepted command, that command is applied, then the FSM goes to OUT.
- OUT:
  - o_hdr_out_valid=1.
  - o_hdr_out, o_wr_cnt and o_conflict are driven from the working registers and held stable until i_hdr_out_ready=1.
  - On handshake, go to IDLE.
- Commands offered in IDLE or OUT are not accepted (o_bit_ready=0); the upstream must hold them.
- A header offered in ACCUM or OUT is not accepted (o_hdr_ready=0).
- Index-to-position mapping is the exact inverse of the extractor: act k maps to byte bit 7-k for all k in 0..7.

## Timing
- Reset values:
  - State is IDLE.
  - o_hdr_ready=1; o_bit_ready=0; o_hdr_out_valid=0.
  - o_hdr_out=0; o_wr_cnt=0; o_conflict=0.
- Header accepted at cycle N: ACCUM from N+1, so the first command can be accepted at N+1.
- Command with last accepted at cycle M: o_hdr_out_valid=1 at M+1.
- Minimum loop with one command and i_hdr_out_ready held high: header at N, command+last at N+1, output at N+2, IDLE at N+3.
- In IDLE, i_hdr_valid and i_bit_act_valid in the same cycle: only the header is taken.
- Counter saturation: with CNT_LEN=4, the 16th and later writes leave o_wr_cnt=15.
- areset asserted in any state: next cycle is IDLE with all outputs at reset values. An in-progress byte is dropped and never emitted.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to ready/valid.

## Structure
- A shared lookup package holds:
  - the state encoding for IDLE/ACCUM/OUT;
  - the MSB-first index-to-position function (7-idx), shared with the extractor;
  - the SUB_PKTS_LEN/L_BIT_ACT_LEN defaults.
- Sub-module sub1_bit_deposit_core is natural. It is combinational and, from the working byte, written vector, index, value and mask, produces the next byte, next written vector and the conflict hit. The FSM and output registers stay in the top.

## Test plan
- Header 8'h00 accepted. Commands act=0 val=1 and act=7 val=1 (last). Output is 8'h81, o_wr_cnt=1 after the first and 2 at output, o_conflict=0.
- Header 8'hFF. Single command act=3 val=0 mask=1 last. Output 8'hEF, o_wr_cnt=1.
- Header 8'hA5. Single command mask=0 last. Output 8'hA5, o_wr_cnt=0, valid one cycle after the command.
- Header 8'h00. Commands act=2 val=1, then act=2 val=0 last. Output 8'h00, o_conflict=1, o_wr_cnt=2.
- Output held with i_hdr_out_ready=0 for 5 cycles: o_hdr_out stable, o_hdr_ready=0, offered command not accepted. Ready raised: IDLE next cycle.
- areset pulsed in ACCUM after 3 writes: next cycle o_hdr_ready=1 and o_hdr_out_valid=0. A following header 8'h0F with command act=4 val=0 last outputs 8'h07.
